// File: rtl/spi_fifo_serializer.sv
// spi_fifo_serializer
// Pulls one word from a source FIFO when it reports a ready word and shifts it
// out MSB first as an SPI mode-0 stream (sclk idles low, data changes while
// sclk is low, receiver samples on the sclk rising edge). A one-cycle done
// pulse marks the end of each word.
//
// mosi is taken straight from the MSB of the shift register, so it is a flop
// output like sclk and done. The register is shifted once more after the last
// bit, which leaves it all zero and returns mosi to 0 for DONE and IDLE
// without a separate clear.

module spi_fifo_serializer #(
    parameter int DATAWIDTH       = 8,
    parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 full,
    input  logic                 empty,
    input  logic [DATAWIDTH-1:0] read_data,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT_LOW  = 2'd1,
        SHIFT_HIGH = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [BITCOUNTERWIDTH-1:0] LAST_BIT = BITCOUNTERWIDTH'(DATAWIDTH - 1);
    localparam logic [BITCOUNTERWIDTH-1:0] ONE      = BITCOUNTERWIDTH'(1);

    state_t                     state;
    logic [DATAWIDTH-1:0]       shift_reg;
    logic [BITCOUNTERWIDTH-1:0] bitcnt;
    logic                       start;

    // A word is only taken when the flags agree that one is available;
    // full together with empty is contradictory and is treated as "not ready".
    assign start = full && !empty;

    assign mosi = shift_reg[DATAWIDTH-1];

    // Transfer sequencer: two clock cycles per bit (sclk low, then high),
    // then a single DONE cycle before the next start can be sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bitcnt    <= '0;
            sclk      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sclk <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        shift_reg <= read_data;
                        bitcnt    <= LAST_BIT;
                        state     <= SHIFT_LOW;
                    end
                end

                SHIFT_LOW: begin
                    sclk  <= 1'b1;
                    state <= SHIFT_HIGH;
                end

                SHIFT_HIGH: begin
                    sclk      <= 1'b0;
                    shift_reg <= {shift_reg[DATAWIDTH-2:0], 1'b0};
                    if (bitcnt != '0) begin
                        bitcnt <= bitcnt - ONE;
                        state  <= SHIFT_LOW;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fifo_serializer.sv
// tb_spi_fifo_serializer
// Table of start/no-start vectors run with a cycle-exact expected waveform,
// a scoreboard of expected mosi bits popped on every sclk rising edge, and
// hand-written sequences for reset abort, idle hold and continuous streaming.

module tb_spi_fifo_serializer;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          full;
    logic          empty;
    logic [DW-1:0] read_data;
    logic          sclk;
    logic          mosi;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic sb_bits[$];
    logic prev_sclk = 1'b0;
    logic prev_done = 1'b0;
    int   edge_count = 0;
    int   done_count = 0;

    typedef struct {
        logic          full;
        logic          empty;
        logic [DW-1:0] data;
        bit            disturb;
        bit            exp_start;
    } vec_t;

    vec_t vecs[9];

    spi_fifo_serializer #(.DATAWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .full      (full),
        .empty     (empty),
        .read_data (read_data),
        .sclk      (sclk),
        .mosi      (mosi),
        .done      (done)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every sclk rising edge must carry the next expected
    // bit, and every done pulse must close a word of exactly DW sclk edges.
    always @(negedge clk) begin
        if (rst) begin
            prev_sclk  = 1'b0;
            prev_done  = 1'b0;
            edge_count = 0;
        end else begin
            if (sclk && !prev_sclk) begin
                edge_count++;
                checks++;
                if (sb_bits.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected_sclk: got sclk edge with mosi=%0b, required no transfer", mosi);
                end else begin
                    logic exp_bit;
                    exp_bit = sb_bits.pop_front();
                    if (mosi !== exp_bit) begin
                        errors++;
                        $display("[TB] FAIL sb_mosi: got %0b required %0b", mosi, exp_bit);
                    end
                end
            end
            if (done) begin
                done_count++;
                checks++;
                if (edge_count != DW || prev_done) begin
                    errors++;
                    $display("[TB] FAIL sclk_edges_per_done: got %0d edges (prev_done=%0b) required %0d edges (prev_done=0)",
                             edge_count, prev_done, DW);
                end
                edge_count = 0;
            end
            prev_sclk = sclk;
            prev_done = done;
        end
    end

    task automatic checkOutput(input string name, input logic es, input logic em, input logic ed);
        checks++;
        if ({sclk, mosi, done} !== {es, em, ed}) begin
            errors++;
            $display("[TB] FAIL %s: got sclk=%0b mosi=%0b done=%0b required sclk=%0b mosi=%0b done=%0b",
                     name, sclk, mosi, done, es, em, ed);
        end
    endtask

    task automatic pushWord(input logic [DW-1:0] word);
        for (int b = DW - 1; b >= 0; b--) sb_bits.push_back(word[b]);
    endtask

    // Called just after a negedge with the DUT idle; ends just after a negedge.
    task automatic applyStimulus(input vec_t v, input string name);
        full      = v.full;
        empty     = v.empty;
        read_data = v.data;
        if (v.exp_start) begin
            pushWord(v.data);
            for (int i = 0; i < 2 * DW + 2; i++) begin
                logic es;
                logic em;
                logic ed;
                @(posedge clk);
                @(negedge clk);
                es = (i < 2 * DW) && (i % 2 == 1);
                em = (i < 2 * DW) ? v.data[DW - 1 - i / 2] : 1'b0;
                ed = (i == 2 * DW);
                checkOutput($sformatf("%s_c%0d", name, i), es, em, ed);
                if (i >= 2 * DW - 1) begin
                    full  = 1'b0;
                    empty = 1'b1;
                end else if (v.disturb) begin
                    full      = 1'($urandom_range(0, 1));
                    empty     = 1'($urandom_range(0, 1));
                    read_data = (i == 3) ? 8'h3C : DW'($urandom);
                end else begin
                    full  = 1'b0;
                    empty = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                @(negedge clk);
                checkOutput($sformatf("%s_idle%0d", name, i), 1'b0, 1'b0, 1'b0);
            end
            full  = 1'b0;
            empty = 1'b1;
        end
    endtask

    initial begin
        vecs[0] = '{full: 1'b1, empty: 1'b0, data: 8'hA5, disturb: 1'b0, exp_start: 1'b1};
        vecs[1] = '{full: 1'b1, empty: 1'b1, data: 8'hA5, disturb: 1'b0, exp_start: 1'b0};
        vecs[2] = '{full: 1'b0, empty: 1'b0, data: 8'h5A, disturb: 1'b0, exp_start: 1'b0};
        vecs[3] = '{full: 1'b0, empty: 1'b1, data: 8'hFF, disturb: 1'b0, exp_start: 1'b0};
        vecs[4] = '{full: 1'b1, empty: 1'b0, data: 8'hA5, disturb: 1'b1, exp_start: 1'b1};
        vecs[5] = '{full: 1'b1, empty: 1'b0, data: 8'h80, disturb: 1'b0, exp_start: 1'b1};
        vecs[6] = '{full: 1'b1, empty: 1'b0, data: 8'h01, disturb: 1'b0, exp_start: 1'b1};
        vecs[7] = '{full: 1'b1, empty: 1'b0, data: 8'hFF, disturb: 1'b1, exp_start: 1'b1};
        vecs[8] = '{full: 1'b1, empty: 1'b0, data: 8'h00, disturb: 1'b0, exp_start: 1'b1};

        rst       = 1'b1;
        full      = 1'b1;
        empty     = 1'b0;
        read_data = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0);
        full  = 1'b0;
        empty = 1'b1;
        rst   = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) applyStimulus(vecs[v], $sformatf("vec%0d", v));

        // full low with random data and empty: nothing may move
        for (int i = 0; i < 20; i++) begin
            full      = 1'b0;
            empty     = 1'($urandom_range(0, 1));
            read_data = DW'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("full_low_c%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // reset in the middle of a word aborts it without a done pulse
        begin
            int dones_before;
            dones_before = done_count;
            full      = 1'b1;
            empty     = 1'b0;
            read_data = 8'hA5;
            pushWord(8'hA5);
            @(posedge clk);
            @(negedge clk);
            full  = 1'b0;
            empty = 1'b1;
            repeat (6) @(posedge clk);
            #2 rst = 1'b1;
            #1 checkOutput("reset_abort_immediate", 1'b0, 1'b0, 1'b0);
            sb_bits.delete();
            @(negedge clk);
            checkOutput("reset_abort_held", 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                @(negedge clk);
                checkOutput($sformatf("post_reset_idle%0d", i), 1'b0, 1'b0, 1'b0);
            end
            checks++;
            if (done_count != dones_before) begin
                errors++;
                $display("[TB] FAIL reset_no_done: got %0d done pulses required 0", done_count - dones_before);
            end
        end

        applyStimulus(vecs[0], "after_reset");

        // full held high: a new word starts every 2*DW+2 cycles
        begin
            int dones_before;
            dones_before = done_count;
            full  = 1'b1;
            empty = 1'b0;
            for (int c = 0; c < 17 * (2 * DW + 2); c++) begin
                read_data = DW'($urandom);
                if (c % (2 * DW + 2) == 0) pushWord(read_data);
                @(posedge clk);
                @(negedge clk);
            end
            full  = 1'b0;
            empty = 1'b1;
            repeat (4) begin
                @(posedge clk);
                @(negedge clk);
            end
            checks++;
            if (done_count - dones_before != 17) begin
                errors++;
                $display("[TB] FAIL stream_done_count: got %0d required 17", done_count - dones_before);
            end
            checks++;
            if (sb_bits.size() != 0) begin
                errors++;
                $display("[TB] FAIL stream_bits_left: got %0d unsent bits required 0", sb_bits.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
